// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the double-precision FPU issue path.
//   fpu_op_t        - 4-bit opcode; encodings 13..15 are unassigned and are
//                     treated as single-cycle pass-through operations.
//   lat_class_t     - latency class an opcode belongs to.
//   sched_state_t   - issue scheduler states.
//   latClassOf()    - opcode -> latency class mapping.
//   DEF_*_LAT       - default FPU latencies per class (cycles).
package fpu_pkg;

  typedef enum logic [3:0] {
    FOP_ADD   = 4'd0,
    FOP_SUB   = 4'd1,
    FOP_MIN   = 4'd2,
    FOP_MAX   = 4'd3,
    FOP_CMP   = 4'd4,
    FOP_MUL   = 4'd5,
    FOP_FMADD = 4'd6,
    FOP_FMSUB = 4'd7,
    FOP_DIV   = 4'd8,
    FOP_SQRT  = 4'd9,
    FOP_CVT   = 4'd10,
    FOP_SGNJ  = 4'd11,
    FOP_CLASS = 4'd12
  } fpu_op_t;

  typedef enum logic [2:0] {
    LC_ADD, LC_MUL, LC_FMA, LC_DIV, LC_SQRT, LC_MISC
  } lat_class_t;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_RESP
  } sched_state_t;

  localparam int DEF_ADD_LAT  = 3;
  localparam int DEF_MUL_LAT  = 4;
  localparam int DEF_FMA_LAT  = 5;
  localparam int DEF_DIV_LAT  = 22;
  localparam int DEF_SQRT_LAT = 28;
  localparam int DEF_MISC_LAT = 1;

  // Anything not explicitly arithmetic (including unassigned encodings)
  // falls into the short MISC class.
  function automatic lat_class_t latClassOf(input fpu_op_t op);
    case (op)
      FOP_ADD, FOP_SUB, FOP_MIN, FOP_MAX, FOP_CMP: return LC_ADD;
      FOP_MUL:                                     return LC_MUL;
      FOP_FMADD, FOP_FMSUB:                        return LC_FMA;
      FOP_DIV:                                     return LC_DIV;
      FOP_SQRT:                                    return LC_SQRT;
      default:                                     return LC_MISC;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n  - clock, synchronous active-low reset
//   req[1:0]    - request lines
//   advance     - the current grant was accepted; pass priority on
//   grant[1:0]  - one-hot grant (zero when no request)
module rr_arb2
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr_q names the requester that wins when both are requesting.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else              grant = req;
  end

  // Priority moves to the requester that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dfpu_sched.sv
// dfpu_sched: single-issue scheduler for the double-precision FPU.
//   clk, rst_n                  - clock, synchronous active-low reset
//   reqValid/reqReady [1:0]     - request handshake per requester
//   reqOp/reqA/reqB/reqC/reqTag - request payload per requester
//   flush                       - abort in-flight work, drop pending response
//   fpuOpA/B/C, fpuOp           - latched operands/opcode to the FPU
//   fpuEnable                   - one-cycle start pulse
//   fpuResult, fpuFlags         - FPU outputs, sampled when the latency expires
//   rspValid/rspReady           - response handshake
//   rspData/rspFlags/rspTag/rspId - response payload
//   busy                        - an operation is in flight or awaiting pickup
module dfpu_sched
  import fpu_pkg::*;
#(
  parameter int ADD_LAT  = DEF_ADD_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int FMA_LAT  = DEF_FMA_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int SQRT_LAT = DEF_SQRT_LAT,
  parameter int MISC_LAT = DEF_MISC_LAT,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
  input  fpu_op_t          reqOp  [2],
  input  logic [63:0]      reqA   [2],
  input  logic [63:0]      reqB   [2],
  input  logic [63:0]      reqC   [2],
  input  logic [TAG_W-1:0] reqTag [2],
  input  logic             flush,
  output logic [63:0]      fpuOpA,
  output logic [63:0]      fpuOpB,
  output logic [63:0]      fpuOpC,
  output fpu_op_t          fpuOp,
  output logic             fpuEnable,
  input  logic [63:0]      fpuResult,
  input  logic [6:0]       fpuFlags,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [63:0]      rspData,
  output logic [6:0]       rspFlags,
  output logic [TAG_W-1:0] rspTag,
  output logic             rspId,
  output logic             busy
);

  // The 5-bit down-counter limits every latency to 1..31.
  if (ADD_LAT < 1 || ADD_LAT > 31 || MUL_LAT < 1 || MUL_LAT > 31 ||
      FMA_LAT < 1 || FMA_LAT > 31 || DIV_LAT < 1 || DIV_LAT > 31 ||
      SQRT_LAT < 1 || SQRT_LAT > 31 || MISC_LAT < 1 || MISC_LAT > 31) begin : gBadLat
    $fatal(1, "dfpu_sched: latency parameters must lie in 1..31");
  end

  function automatic logic [4:0] opLatency(input fpu_op_t op);
    case (latClassOf(op))
      LC_ADD:  return 5'(ADD_LAT);
      LC_MUL:  return 5'(MUL_LAT);
      LC_FMA:  return 5'(FMA_LAT);
      LC_DIV:  return 5'(DIV_LAT);
      LC_SQRT: return 5'(SQRT_LAT);
      default: return 5'(MISC_LAT);
    endcase
  endfunction

  sched_state_t     state_q;
  logic [4:0]       cnt_q;
  logic             fpuEnable_q;
  logic             rspValid_q;
  logic [63:0]      opA_q, opB_q, opC_q;
  fpu_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;
  logic [63:0]      rspData_q;
  logic [6:0]       rspFlags_q;

  logic [1:0] grant;
  logic       canAccept;
  logic       accept;
  logic       gntIdx;

  // Acceptance is withheld during reset and flush so neither can lose a request.
  assign canAccept = (state_q == S_IDLE) && rst_n && !flush;
  assign reqReady  = grant & {2{canAccept}};
  assign accept    = |(reqReady & reqValid);
  assign gntIdx    = grant[1];

  rr_arb2 uArb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (reqValid),
    .advance (accept),
    .grant   (grant)
  );

  // Counter is loaded with L on accept and the FPU is sampled when it reaches
  // zero, so the result is taken L cycles after the enable pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      fpuEnable_q <= 1'b0;
      rspValid_q  <= 1'b0;
      opA_q       <= 64'd0;
      opB_q       <= 64'd0;
      opC_q       <= 64'd0;
      op_q        <= FOP_ADD;
      tag_q       <= '0;
      id_q        <= 1'b0;
      rspData_q   <= 64'd0;
      rspFlags_q  <= 7'd0;
    end else begin
      fpuEnable_q <= 1'b0;
      if (flush) begin
        state_q    <= S_IDLE;
        rspValid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              opA_q       <= reqA[gntIdx];
              opB_q       <= reqB[gntIdx];
              opC_q       <= reqC[gntIdx];
              op_q        <= reqOp[gntIdx];
              tag_q       <= reqTag[gntIdx];
              id_q        <= gntIdx;
              cnt_q       <= opLatency(reqOp[gntIdx]);
              fpuEnable_q <= 1'b1;
              state_q     <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (cnt_q == 5'd0) begin
              rspData_q  <= fpuResult;
              rspFlags_q <= fpuFlags;
              rspValid_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          S_RESP: begin
            if (rspReady) begin
              rspValid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fpuOpA    = opA_q;
  assign fpuOpB    = opB_q;
  assign fpuOpC    = opC_q;
  assign fpuOp     = op_q;
  assign fpuEnable = fpuEnable_q;
  assign rspValid  = rspValid_q;
  assign rspData   = rspData_q;
  assign rspFlags  = rspFlags_q;
  assign rspTag    = tag_q;
  assign rspId     = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule
